// File: rtl/sram_axi_bridge_pkg.sv
// sram_axi_bridge_pkg: shared AXI constants (burst, size, default IDs) and the bridge read/write FSM state encodings
package sram_axi_bridge_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [3:0] AXI_INST_ID    = 4'd0;
  localparam logic [3:0] AXI_DATA_ID    = 4'd1;
  typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW_W, W_B} w_state_e;
endpackage

// File: rtl/axi_req_latch.sv
// axi_req_latch: one-deep per-port request register; ports clk/reset, en+d capture when idle, clr releases, busy+q out
module axi_req_latch #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         busy,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      q    <= '0;
    end else if (clr) begin
      busy <= 1'b0;
    end else if (en && !busy) begin
      busy <= 1'b1;
      q    <= d;
    end
  end
endmodule

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: single-beat AXI master for inst fetch and data load/store; sram-like requests in, rvalid pulses + stallreq_axi out, AXI AR/R/AW/W/B
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = AXI_INST_ID,
  parameter logic [3:0] DATA_ID = AXI_DATA_ID
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_rvalid,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_rvalid,
  output logic        stallreq_axi,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  r_state_e    r_state;
  w_state_e    w_state;
  logic        inst_busy, data_busy, r_inst;
  logic [31:0] inst_addr_q;
  logic [67:0] data_q;
  logic [3:0]  data_we_q;
  logic [31:0] data_wdata_q, data_addr_q;
  logic        r_done, inst_clr, data_clr, load_pend, store_pend, unused;
  assign {data_we_q, data_wdata_q, data_addr_q} = data_q;
  // A beat completes the read only if it carries the ID we issued; anything else is drained and dropped.
  assign r_done     = r_state == R_R && rvalid && rlast && rid == arid;
  assign inst_clr   = r_done && r_inst;
  assign data_clr   = (r_done && !r_inst) || (w_state == W_B && bvalid);
  // Loads wait for the write FSM to idle so a load never overtakes an earlier store.
  assign load_pend  = data_busy && data_we_q == 4'd0 && w_state == W_IDLE;
  assign store_pend = data_busy && data_we_q != 4'd0 && w_state == W_IDLE;
  assign stallreq_axi = !reset && (inst_busy || data_busy || inst_sram_en || data_sram_en);
  assign arlen   = 8'd0;
  assign arsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;
  assign awid    = DATA_ID;
  assign awlen   = 8'd0;
  assign awsize  = AXI_SIZE_WORD;
  assign awburst = AXI_BURST_INCR;
  assign wlast   = 1'b1;
  assign unused  = ^{rresp, bresp, bid};
  axi_req_latch #(.W(32)) u_inst (
    .clk(clk), .reset(reset), .en(inst_sram_en), .clr(inst_clr),
    .d(inst_sram_addr), .busy(inst_busy), .q(inst_addr_q)
  );
  axi_req_latch #(.W(68)) u_data (
    .clk(clk), .reset(reset), .en(data_sram_en), .clr(data_clr),
    .d({data_sram_we, data_sram_wdata, data_sram_addr}), .busy(data_busy), .q(data_q)
  );
  // rready stays high outside R_AR so stray or post-reset beats are drained instead of stalling the slave.
  always_ff @(posedge clk) begin
    inst_rvalid <= 1'b0;
    data_rvalid <= 1'b0;
    if (reset) begin
      r_state         <= R_IDLE;
      arvalid         <= 1'b0;
      rready          <= 1'b0;
      arid            <= '0;
      araddr          <= '0;
      r_inst          <= 1'b0;
      inst_sram_rdata <= '0;
      data_sram_rdata <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (load_pend || inst_busy) begin
            arvalid <= 1'b1;
            rready  <= 1'b0;
            r_inst  <= !load_pend;
            arid    <= load_pend ? DATA_ID : INST_ID;
            araddr  <= load_pend ? data_addr_q : inst_addr_q;
            r_state <= R_AR;
          end else begin
            rready <= 1'b1;
          end
        end
        R_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            r_state <= R_R;
          end
        end
        R_R: begin
          if (r_done) begin
            r_state <= R_IDLE;
            if (r_inst) begin
              inst_rvalid     <= 1'b1;
              inst_sram_rdata <= rdata;
            end else begin
              data_rvalid     <= 1'b1;
              data_sram_rdata <= rdata;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      awaddr  <= '0;
      wdata   <= '0;
      wstrb   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (store_pend) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            awaddr  <= data_addr_q;
            wdata   <= data_wdata_q;
            wstrb   <= data_we_q;
            w_state <= W_AW_W;
          end
        end
        W_AW_W: begin
          if (awready) awvalid <= 1'b0;
          if (wready) wvalid <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready  <= 1'b1;
            w_state <= W_B;
          end
        end
        W_B: begin
          if (bvalid) begin
            bready  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge: directed and randomized bridge transactions against a behavioural AXI slave and memory model
module tb_sram_axi_bridge;
  import sram_axi_bridge_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic        inst_sram_en, data_sram_en, inst_rvalid, data_rvalid, stallreq_axi;
  logic [31:0] inst_sram_addr, inst_sram_rdata, data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [3:0]  data_sram_we;
  logic [3:0]  arid, rid, awid, bid, wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  sram_axi_bridge dut (
    .clk(clk), .reset(reset),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata), .inst_rvalid(inst_rvalid),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata), .data_rvalid(data_rvalid),
    .stallreq_axi(stallreq_axi),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [35:0] ar_log [$];
  logic [67:0] w_log [$];
  logic [31:0] ipulse_q [$], dpulse_q [$];
  int last_pulse = -1, b_cyc = -1, aw_hs = 0, w_hs = 0;
  int ar_d = 0, r_d = 0, aw_d = 0, w_d = 0, b_d = 0;
  bit rnd = 1'b0, store_open = 1'b0;
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction
  function automatic logic [31:0] rd_exp(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_fn(a);
  endfunction
  function automatic int dly(input int d);
    return rnd ? int'($urandom_range(0, 4)) : d;
  endfunction
  initial begin
    logic [3:0]  id;
    logic [31:0] a;
    arready = 0; rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
    forever begin
      @(negedge clk);
      if (arvalid) begin
        repeat (dly(ar_d)) @(negedge clk);
        id = arid;
        a  = araddr;
        chk("ar_fixed", {arlen, arsize, arburst}, {8'd0, 3'b010, 2'b01});
        ar_log.push_back({id, a});
        arready = 1; @(negedge clk); arready = 0;
        repeat (dly(r_d)) @(negedge clk);
        rvalid = 1; rlast = 1; rid = id;
        rdata = mem.exists(a) ? mem[a] : mem_fn(a);
        rresp = 2'($urandom_range(0, 3));
        while (!rready) @(negedge clk);
        @(negedge clk); rvalid = 0; rlast = 0;
      end
    end
  end
  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
    forever begin
      @(negedge clk);
      if (awvalid || wvalid) begin
        store_open = 1;
        a = awaddr; d = wdata; s = wstrb;
        chk("aw_fixed", {awid, awlen, awsize, awburst, wlast}, {4'd1, 8'd0, 3'b010, 2'b01, 1'b1});
        w_log.push_back({a, s, d});
        fork
          begin repeat (dly(aw_d)) @(negedge clk); awready = 1; @(negedge clk); awready = 0; end
          begin repeat (dly(w_d)) @(negedge clk); wready = 1; @(negedge clk); wready = 0; end
        join
        mem[a] = merge(mem.exists(a) ? mem[a] : mem_fn(a), d, s);
        repeat (dly(b_d)) @(negedge clk);
        bvalid = 1; bid = 4'd1; bresp = 2'($urandom_range(0, 3));
        while (!bready) @(negedge clk);
        b_cyc = cyc;
        @(negedge clk); bvalid = 0; store_open = 0;
      end
    end
  end
  logic [35:0] prev_ar, prev_aw;
  bit prev_arp = 0, prev_awp = 0;
  always @(negedge clk) begin
    #1;
    if (inst_rvalid) begin ipulse_q.push_back(inst_sram_rdata); last_pulse = cyc; end
    if (data_rvalid) begin dpulse_q.push_back(data_sram_rdata); last_pulse = cyc; end
    if (prev_arp && arvalid) chk("ar_hold", {arid, araddr}, prev_ar);
    if (prev_awp && awvalid) chk("aw_hold", {wstrb, awaddr}, prev_aw);
    if (arvalid && arid == 4'd1) chk("raw_order", store_open, 0);
    if (awvalid) chk("aw_once", aw_hs, 0);
    if (wvalid) chk("w_once", w_hs, 0);
    if (awvalid && awready) aw_hs++;
    if (wvalid && wready) w_hs++;
    prev_arp = arvalid && !arready; prev_ar = {arid, araddr};
    prev_awp = awvalid && !awready; prev_aw = {wstrb, awaddr};
  end
  task automatic clear();
    ipulse_q.delete(); dpulse_q.delete(); ar_log.delete(); w_log.delete();
    last_pulse = -1; b_cyc = -1; aw_hs = 0; w_hs = 0;
  endtask
  task automatic run_txn(input string nm, input bit f, input bit l, input bit s,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dw, input logic [3:0] we);
    int n, exp_drop;
    logic [35:0] exp_ar [$];
    n = 0; exp_drop = -1;
    clear();
    @(negedge clk);
    inst_sram_en = f; inst_sram_addr = ia;
    data_sram_en = l | s; data_sram_we = s ? we : 4'd0; data_sram_addr = da; data_sram_wdata = dw;
    #2 chk({nm, "_stall_en"}, stallreq_axi, 1);
    @(negedge clk); inst_sram_en = 0; data_sram_en = 0;
    #2;
    while (stallreq_axi && n < 300) begin @(negedge clk); #2; n++; end
    chk({nm, "_timeout"}, n < 300, 1);
    if (f || l) exp_drop = last_pulse;
    if (s && b_cyc + 1 > exp_drop) exp_drop = b_cyc + 1;
    chk({nm, "_stall_drop"}, cyc, exp_drop);
    repeat (4) @(negedge clk);
    #2;
    if (l) exp_ar.push_back({AXI_DATA_ID, da});
    if (f) exp_ar.push_back({AXI_INST_ID, ia});
    chk({nm, "_ar_cnt"}, ar_log.size(), exp_ar.size());
    foreach (exp_ar[i]) if (i < ar_log.size()) chk({nm, "_ar"}, ar_log[i], exp_ar[i]);
    chk({nm, "_ipulse_cnt"}, ipulse_q.size(), f);
    if (f && ipulse_q.size() > 0) chk({nm, "_idata"}, ipulse_q[0], rd_exp(ia));
    chk({nm, "_dpulse_cnt"}, dpulse_q.size(), l);
    if (l && dpulse_q.size() > 0) chk({nm, "_ddata"}, dpulse_q[0], rd_exp(da));
    chk({nm, "_w_cnt"}, w_log.size(), s);
    if (s) begin
      if (w_log.size() > 0) chk({nm, "_w"}, w_log[0], {da, we, dw});
      chk({nm, "_hs"}, {aw_hs[7:0], w_hs[7:0]}, 16'h0101);
      chk({nm, "_bready"}, b_cyc >= 0, 1);
      ref_mem[da] = merge(rd_exp(da), dw, we);
    end
    chk({nm, "_idle"}, {arvalid, awvalid, wvalid, bready}, 0);
  endtask
  initial begin
    int n, k;
    logic [31:0] ia, da;
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, k;
    logic [31:0] ia, da;
    inst_sram_en = 1; inst_sram_addr = 32'h1C00_0000;
    data_sram_en = 0; data_sram_we = 0; data_sram_addr = 0; data_sram_wdata = 0;
    reset = 1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_stall", stallreq_axi, 0);
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
    chk("rst_pulses", {inst_rvalid, data_rvalid}, 0);
    inst_sram_en = 0; reset = 0;
    repeat (4) @(negedge clk);
    #2;
    chk("rst_no_ar", ar_log.size(), 0);
    chk("rst_no_pulse", ipulse_q.size() + dpulse_q.size(), 0);
    mem[32'h1C00_0000] = 32'h0280_0C00;
    ref_mem[32'h1C00_0000] = 32'h0280_0C00;
    ar_d = 2; r_d = 3;
    run_txn("fetch", 1, 0, 0, 32'h1C00_0000, 0, 0, 0);
    ar_d = 1; r_d = 1;
    run_txn("fetch_load", 1, 1, 0, 32'h1C00_0010, 32'h0000_1000, 0, 0);
    aw_d = 3; w_d = 0; b_d = 2;
    run_txn("store", 0, 0, 1, 0, 32'h0000_2004, 32'hDEAD_BEEF, 4'b0011);
    aw_d = 1; w_d = 1; b_d = 0;
    run_txn("store_same", 0, 0, 1, 0, 32'h0000_2008, 32'h1234_5678, 4'b1111);
    clear();
    aw_d = 1; w_d = 2; b_d = 3;
    @(negedge clk);
    data_sram_en = 1; data_sram_we = 4'b1100; data_sram_addr = 32'h0000_2004; data_sram_wdata = 32'hCAFE_0000;
    @(negedge clk);
    data_sram_we = 4'b0000;
    @(negedge clk);
    data_sram_en = 0;
    n = 0;
    #2;
    while (stallreq_axi && n < 300) begin @(negedge clk); #2; n++; end
    chk("raw_timeout", n < 300, 1);
    chk("raw_no_ar", ar_log.size(), 0);
    chk("raw_w_cnt", w_log.size(), 1);
    ref_mem[32'h0000_2004] = merge(rd_exp(32'h0000_2004), 32'hCAFE_0000, 4'b1100);
    run_txn("raw_load", 0, 1, 0, 0, 32'h0000_2004, 0, 0);
    rnd = 1;
    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(0, 4);
      ia = 32'h1C00_0000 | ($urandom_range(0, 255) << 2);
      da = 32'h0000_2000 | ($urandom_range(0, 63) << 2);
      run_txn($sformatf("rnd%0d", i), k == 0 || k == 3 || k == 4, k == 1 || k == 3, k == 2 || k == 4,
              ia, da, $urandom, 4'($urandom_range(1, 15)));
    end
    rnd = 0; ar_d = 0; r_d = 8;
    clear();
    @(negedge clk);
    inst_sram_en = 1; inst_sram_addr = 32'h1C00_0040;
    @(negedge clk);
    inst_sram_en = 0;
    n = 0;
    #2;
    while (ar_log.size() == 0 && n < 50) begin @(negedge clk); #2; n++; end
    chk("rst_mid_ar", ar_log.size(), 1);
    repeat (2) @(negedge clk);
    #2 chk("rst_mid_rready", rready, 1);
    reset = 1;
    @(negedge clk);
    #2;
    chk("rst_mid_stall", stallreq_axi, 0);
    chk("rst_mid_valids", {arvalid, rready, awvalid, wvalid, bready, inst_rvalid, data_rvalid}, 0);
    reset = 0;
    repeat (15) @(negedge clk);
    #2;
    chk("rst_mid_no_pulse", ipulse_q.size() + dpulse_q.size(), 0);
    chk("rst_mid_no_reissue", ar_log.size(), 1);
    chk("rst_mid_idle", {arvalid, stallreq_axi, rvalid}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_axi_bridge.md
SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 Parameter INST_ID, default 4'd0: AXI ID for instruction reads.
REQ-002 Parameter DATA_ID, default 4'd1: AXI ID for data reads and writes.
REQ-003 clk  in  1: single clock; every register samples on its rising edge.
REQ-004 reset  in  1: synchronous, active-high reset.
REQ-005 inst_sram_en, inst_sram_addr  in  1, 32: instruction fetch request and word address.
REQ-006 inst_sram_rdata, inst_rvalid  out  32, 1: fetched word and a one-cycle return pulse.
REQ-007 data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata  in  1, 4, 32, 32: data request; we==0 is a load.
REQ-008 data_sram_rdata, data_rvalid  out  32, 1: load word and a one-cycle return pulse.
REQ-009 stallreq_axi  out  1: pipeline stall request to pip_ctrl.
REQ-010 AR channel: arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arvalid out; arready in.
REQ-011 R channel: rid 4, rdata 32, rresp 2, rlast 1, rvalid in; rready out.
REQ-012 AW/W channels: awid 4, awaddr 32, awlen 8, awsize 3, awburst 2, awvalid, wdata 32, wstrb 4, wlast, wvalid out; awready, wready in.
REQ-013 B channel: bid 4, bresp 2, bvalid in; bready out.

Function
REQ-014 All transfers SHALL be single-beat: arlen=awlen=0, arsize=awsize=3'b010, arburst=awburst=2'b01, wlast=1.
REQ-015 The read FSM SHALL use the states R_IDLE, R_AR (arvalid held until arready) and R_R (rready=1 until rvalid&&rlast).
REQ-016 In R_IDLE, a pending data load SHALL win over a pending instruction fetch; the loser SHALL stay latched and pending.
REQ-017 Each request SHALL be latched the cycle its en is high; address, ID and wstrb SHALL stay stable while the matching valid is high.
REQ-018 On rvalid&&rlast, the bridge SHALL route the beat by rid (INST_ID goes to inst, DATA_ID goes to data), pulse the matching *_rvalid for 1 cycle with rdata registered, and return to R_IDLE.
REQ-019 The write FSM SHALL use the states W_IDLE, W_AW_W and W_B.
REQ-020 In W_AW_W, awvalid and wvalid SHALL each drop independently on their own handshake; the FSM SHALL go to W_B when both have completed, including completion in the same cycle.
REQ-021 In W_B, bready SHALL be 1; on bvalid the FSM SHALL return to W_IDLE.
REQ-022 wstrb SHALL equal the latched data_sram_we, and wdata the latched wdata.
REQ-023 A data load SHALL NOT issue AR while the write FSM is not in W_IDLE (read-after-write ordering).
REQ-024 stallreq_axi SHALL be combinationally 1 while any latched request is not yet returned (load or fetch) or acknowledged (store, on bvalid), and also in the cycle a new en arrives; it SHALL be 0 in the cycle of the final return pulse.
REQ-025 At most one outstanding request per port; a new en while that port is busy SHALL be ignored, because the pipeline is stalled.
REQ-026 A nonzero rresp or bresp SHALL be treated as a normal completion; no exception is raised.
REQ-027 rvalid with an unexpected rid, or while not in R_R, SHALL be accepted and discarded.

Reset
REQ-028 While reset=1: both FSMs SHALL be in their IDLE states, all valid/ready outputs 0, rvalid pulses 0, stallreq_axi 0, and latched requests cleared.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction; late R/B beats after reset SHALL be discarded per REQ-027.

Structure
REQ-030 The AXI constants (burst INCR, size WORD, INST_ID/DATA_ID defaults) and the FSM state encodings SHALL live in the shared CPU defines package.
REQ-031 One sub-module, axi_req_latch (a per-port request register with a busy flag), SHALL be instantiated twice, once for inst and once for data.

Verification
REQ-032 Fetch 0x1C000000; arready=1 after 2 cycles, R beat 0x02800C00 after 3 more -> one AR (arid 0, araddr 0x1C000000), inst_rvalid pulse with 0x02800C00, stall drops the same cycle.
REQ-033 Fetch and load (0x00001000) in the same cycle -> AR issues DATA_ID first, then INST_ID; both return pulses are correct; stall stays high until the second pulse.
REQ-034 Store we=4'b0011, 0xDEADBEEF to 0x00002004; wready 3 cycles before awready -> W and AW each complete once, wstrb=0011, bready asserted, stall clears on bvalid.
REQ-035 Store then immediate load of 0x00002004 -> no arvalid before bvalid of the store.
REQ-036 Reset pulsed while in R_R, then an rvalid arrives -> outputs at reset values, no rvalid pulse, FSM stays in R_IDLE.
